// File: rtl/ama_riscv_mem_responder_pkg.sv
// Shared memory-bus definitions for the icache/dcache memory side.
package ama_riscv_defines;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_DATA_BUS = 128;
    localparam int MEM_TRANSFERS_PER_CL = 4;

    // one slot of a response delay line
    typedef struct packed {
        logic                    valid;
        logic [MEM_DATA_BUS-1:0] data;
    } mem_rsp_stage_t;

endpackage

// File: rtl/ama_riscv_mem_responder_if.sv
// Generic ready/valid channel. TX/master drives valid+data, RX/slave drives ready.
interface rv_if #(
    parameter int W = 32
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport TX     (output valid, output data, input ready);
    modport RX     (input valid, input data, output ready);
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ama_riscv_mem_responder_rsp_pipe.sv
// LATENCY-stage {valid, data} delay line with synchronous clear.
// Data is cleared along with valid so an empty slot never carries stale data.
module ama_riscv_mem_rsp_pipe
    import ama_riscv_defines::*;
#(
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           clr,
    input  mem_rsp_stage_t d,
    output mem_rsp_stage_t q
);

    mem_rsp_stage_t stage [LATENCY];

    // shift one stage per cycle, flush everything on clear
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[LATENCY-1];

endmodule

// File: rtl/ama_riscv_mem_responder.sv
// Main-memory responder for icache line fills: one 16B-word read accepted per
// cycle, returned in order exactly LATENCY cycles later; backdoor write port
// for preloading. Optional macro MEM_RSP_PERF_EN adds request/burst counters.
module ama_riscv_mem_responder
    import ama_riscv_defines::*;
#(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    rv_if.RX                        req,
    rv_if.TX                        rsp,
    input  logic                    wr_en,
    input  logic [MEM_ADDR_BUS-1:0] wr_addr,
    input  logic [MEM_DATA_BUS-1:0] wr_data,
    output logic                    oor_err
`ifdef MEM_RSP_PERF_EN
    ,
    output logic [31:0]             perf_req_cnt,
    output logic [31:0]             perf_burst_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [MEM_ADDR_BUS-1:0] DEPTH_A = MEM_ADDR_BUS'(DEPTH);

    logic [MEM_DATA_BUS-1:0] mem [DEPTH];
    logic                    ready_q;
    logic                    req_acc;
    logic                    req_oor;
    logic                    wr_oor;
    mem_rsp_stage_t          pipe_in;
    mem_rsp_stage_t          pipe_out;

    // ready is held low during reset and for one cycle after it drops
    assign req.ready = ready_q && !rst;
    assign req_acc   = req.valid && req.ready;
    assign req_oor   = req.data >= DEPTH_A;
    assign wr_oor    = wr_addr >= DEPTH_A;

    // ready register: one cycle of hold-off after reset
    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    // sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)                     oor_err <= 1'b0;
        else if (req_acc && req_oor) oor_err <= 1'b1;
    end

    // backdoor write; array is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (wr_en && !wr_oor) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // read happens before the same-edge write lands, so a colliding read sees old data
    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = req_acc;
        if (req_acc && !req_oor) pipe_in.data = mem[req.data[IDX_W-1:0]];
    end

    ama_riscv_mem_rsp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk (clk),
        .clr (rst),
        .d   (pipe_in),
        .q   (pipe_out)
    );

    // rsp.ready is informational only: the icache drops it on its last fill beat
    assign rsp.valid = pipe_out.valid;
    assign rsp.data  = pipe_out.data;

`ifdef MEM_RSP_PERF_EN
    logic acc_q;

    // accepted-request and burst-start counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= 1'b0;
            perf_req_cnt   <= '0;
            perf_burst_cnt <= '0;
        end else begin
            acc_q <= req_acc;
            if (req_acc)           perf_req_cnt   <= perf_req_cnt + 32'd1;
            if (req_acc && !acc_q) perf_burst_cnt <= perf_burst_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    logic [LATENCY-1:0] acc_hist;

    // acceptance history aligned with the response pipe for the protocol check
    always_ff @(posedge clk) begin
        if (rst) acc_hist <= '0;
        else     acc_hist <= LATENCY'({acc_hist, req_acc});
    end

    a_rsp_unclaimed: assert property (@(posedge clk) disable iff (rst)
        (rsp.valid && !rsp.ready) |-> acc_hist[LATENCY-1])
        else $error("mem_responder: rsp.valid without ready and no matching request");
`endif

endmodule
